// File: rtl/mac_pkg.sv
// Shared definitions for the mac_array sequencer: FSM state encoding and
// the instruction codes driven onto mac_array inst_w.
package mac_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      EXEC  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [2:0] INST_IDLE = 3'b000;
   localparam logic [2:0] INST_LOAD = 3'b001;
   localparam logic [2:0] INST_EXEC = 3'b010;

   // Psums can only be produced once the array has seen data, so counting is
   // limited to the states that follow an accepted start.
   function automatic logic is_counting(state_e s);
      return (s == LOAD) || (s == EXEC) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/mac_out_collector.sv
// Output side of the sequencer: registers the array psums, flags complete
// psum cycles and counts them up to the requested vector count.
module mac_out_collector #(
   parameter int psum_bw = 16,
   parameter int col     = 1,
   parameter int cnt_bw  = 10
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear_i,
   input  logic                   count_en_i,
   input  logic [cnt_bw-1:0]      num_vec_i,
   input  logic [psum_bw*col-1:0] out_s_i,
   input  logic [col-1:0]         valid_i,
   output logic [psum_bw*col-1:0] psum_out_o,
   output logic                   psum_vld_o,
   output logic [cnt_bw-1:0]      count_o
);

   logic [psum_bw*col-1:0] psum_q;
   logic                   vld_q;
   logic [cnt_bw-1:0]      count_q, count_d;
   logic                   all_vld;

   assign all_vld = &valid_i;

   // Extra valid cycles past num_vec still reach psum_vld but leave the count alone.
   always_comb begin
      count_d = count_q;
      if (clear_i)
         count_d = '0;
      else if (count_en_i && all_vld && (count_q < num_vec_i))
         count_d = count_q + cnt_bw'(1);
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         psum_q  <= '0;
         vld_q   <= 1'b0;
         count_q <= '0;
      end else begin
         psum_q  <= out_s_i;
         vld_q   <= all_vld;
         count_q <= count_d;
      end
   end

   assign psum_out_o = psum_q;
   assign psum_vld_o = vld_q;
   assign count_o    = count_q;

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequencer for one mac_array: loads the kernel, streams activation vectors
// from SRAM, collects the resulting psums and reports completion.
module mac_array_ctrl
   import mac_pkg::*;
#(
   parameter int bw        = 4,
   parameter int psum_bw   = 16,
   parameter int row       = 8,
   parameter int col       = 1,
   parameter int addr_bw   = 10,
   parameter int cnt_bw    = 10,
   parameter int drain_max = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [addr_bw-1:0]     kern_base,
   input  logic [addr_bw-1:0]     act_base,
   input  logic [cnt_bw-1:0]      num_vec,
   output logic                   mem_rd,
   output logic [addr_bw-1:0]     mem_addr,
   input  logic [row*bw-1:0]      mem_q,
   output logic [row*bw-1:0]      in_w,
   output logic [psum_bw*col-1:0] in_n,
   output logic [2:0]             inst_w,
   input  logic [psum_bw*col-1:0] out_s,
   input  logic [col-1:0]         valid,
   output logic [psum_bw*col-1:0] psum_out,
   output logic                   psum_vld,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   localparam int                DRAIN_BW   = $clog2(drain_max + 1);
   localparam logic [cnt_bw-1:0] COL_CNT    = cnt_bw'(col);
   localparam logic [DRAIN_BW-1:0] DRAIN_LAST = DRAIN_BW'(drain_max - 1);

   state_e               state_q;
   logic [addr_bw-1:0]   kern_base_q, act_base_q;
   logic [cnt_bw-1:0]    num_vec_q;
   logic [cnt_bw-1:0]    ld_cnt_q, vec_cnt_q;
   logic [DRAIN_BW-1:0]  drain_cnt_q;
   logic                 mem_rd_q;
   logic [addr_bw-1:0]   mem_addr_q;
   logic [2:0]           issue_q, inst_q;
   logic                 busy_q, done_q, err_q;

   logic                 accept;
   logic [cnt_bw-1:0]    psum_cnt;

   assign accept = (state_q == IDLE) && start;

   // ld_cnt_q / vec_cnt_q hold the number of reads already issued, including
   // the one on the bus this cycle, so they double as the next address offset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         kern_base_q <= '0;
         act_base_q  <= '0;
         num_vec_q   <= '0;
         ld_cnt_q    <= '0;
         vec_cnt_q   <= '0;
         drain_cnt_q <= '0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         issue_q     <= INST_IDLE;
         inst_q      <= INST_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         // inst_w trails the read by one cycle so it lines up with mem_q.
         inst_q <= issue_q;
         case (state_q)
            IDLE: begin
               if (start) begin
                  kern_base_q <= kern_base;
                  act_base_q  <= act_base;
                  num_vec_q   <= num_vec;
                  err_q       <= 1'b0;
                  ld_cnt_q    <= cnt_bw'(1);
                  vec_cnt_q   <= '0;
                  drain_cnt_q <= '0;
                  mem_rd_q    <= 1'b1;
                  mem_addr_q  <= kern_base;
                  issue_q     <= INST_LOAD;
                  busy_q      <= 1'b1;
                  state_q     <= LOAD;
               end
            end
            LOAD: begin
               if (ld_cnt_q == COL_CNT) begin
                  if (num_vec_q == '0) begin
                     mem_rd_q   <= 1'b0;
                     mem_addr_q <= '0;
                     issue_q    <= INST_IDLE;
                     done_q     <= 1'b1;
                     state_q    <= DONE;
                  end else begin
                     mem_addr_q <= act_base_q;
                     issue_q    <= INST_EXEC;
                     vec_cnt_q  <= cnt_bw'(1);
                     state_q    <= EXEC;
                  end
               end else begin
                  mem_addr_q <= kern_base_q + addr_bw'(ld_cnt_q);
                  ld_cnt_q   <= ld_cnt_q + cnt_bw'(1);
               end
            end
            EXEC: begin
               if (vec_cnt_q == num_vec_q) begin
                  mem_rd_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  issue_q     <= INST_IDLE;
                  drain_cnt_q <= '0;
                  state_q     <= DRAIN;
               end else begin
                  mem_addr_q <= act_base_q + addr_bw'(vec_cnt_q);
                  vec_cnt_q  <= vec_cnt_q + cnt_bw'(1);
               end
            end
            DRAIN: begin
               if (psum_cnt >= num_vec_q) begin
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (drain_cnt_q == DRAIN_LAST) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DRAIN_BW'(1);
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   mac_out_collector #(
      .psum_bw (psum_bw),
      .col     (col),
      .cnt_bw  (cnt_bw)
   ) u_collector (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (accept),
      .count_en_i (is_counting(state_q)),
      .num_vec_i  (num_vec_q),
      .out_s_i    (out_s),
      .valid_i    (valid),
      .psum_out_o (psum_out),
      .psum_vld_o (psum_vld),
      .count_o    (psum_cnt)
   );

   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;
   assign in_w     = mem_q;
   assign in_n     = '0;
   assign inst_w   = inst_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Directed bench for mac_array_ctrl with an SRAM model and a one-column
// dot-product model standing in for mac_array.
module tb_mac_array_ctrl;

   localparam int BW = 4, PSUM_BW = 16, ROW = 8, COL = 1;
   localparam int ADDR_BW = 10, CNT_BW = 10, DRAIN_MAX = 32;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic                   start = 1'b0;
   logic [ADDR_BW-1:0]     kern_base = '0, act_base = '0;
   logic [CNT_BW-1:0]      num_vec = '0;
   logic                   mem_rd;
   logic [ADDR_BW-1:0]     mem_addr;
   logic [ROW*BW-1:0]      mem_q = '0;
   logic [ROW*BW-1:0]      in_w;
   logic [PSUM_BW*COL-1:0] in_n;
   logic [2:0]             inst_w;
   logic [PSUM_BW*COL-1:0] out_s = '0;
   logic [COL-1:0]         valid = '0;
   logic [PSUM_BW*COL-1:0] psum_out;
   logic                   psum_vld, busy, done, err;

   mac_array_ctrl #(
      .bw(BW), .psum_bw(PSUM_BW), .row(ROW), .col(COL),
      .addr_bw(ADDR_BW), .cnt_bw(CNT_BW), .drain_max(DRAIN_MAX)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .kern_base(kern_base), .act_base(act_base), .num_vec(num_vec),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
      .in_w(in_w), .in_n(in_n), .inst_w(inst_w),
      .out_s(out_s), .valid(valid),
      .psum_out(psum_out), .psum_vld(psum_vld),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // SRAM and array models
   logic [ROW*BW-1:0] sram [0:(1<<ADDR_BW)-1];
   logic [ROW*BW-1:0] kern_r = '0;
   logic              valid_off = 1'b0;

   function automatic logic [PSUM_BW-1:0] dot(input logic [31:0] a, input logic [31:0] b);
      logic [PSUM_BW-1:0] s;
      s = '0;
      for (int i = 0; i < ROW; i++)
         s = s + PSUM_BW'(a[4*i +: 4] * b[4*i +: 4]);
      return s;
   endfunction

   always @(posedge clk) begin
      if (mem_rd) mem_q <= sram[mem_addr];
      if (inst_w == 3'b001) kern_r <= in_w;
      valid <= (inst_w == 3'b010) && !valid_off;
      out_s <= dot(kern_r, in_w);
   end

   // Monitor, sampled on the falling edge
   int cyc = 0, done_cnt = 0, done_cyc = 0, busy_gap = 0;
   int first_rd = 0, last_rd = 0, first_inst = 0, start_cyc = 0;
   bit in_op = 1'b0;
   int addr_log[$], inst_log[$], psum_log[$];
   int exp_addr[$], exp_inst[$], exp_psum[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (mem_rd) begin
         if (addr_log.size() == 0) first_rd = cyc;
         last_rd = cyc;
         addr_log.push_back(int'(mem_addr));
      end
      if (inst_w != 3'b000) begin
         if (inst_log.size() == 0) first_inst = cyc;
         inst_log.push_back(int'(inst_w));
      end
      if (psum_vld) psum_log.push_back(int'(psum_out));
      if (in_op && !busy) busy_gap = busy_gap + 1;
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
         in_op = 1'b0;
      end
   end

   int n_checks = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      addr_log.delete();
      inst_log.delete();
      psum_log.delete();
      busy_gap = 0;
   endtask

   task automatic pulse_start(input int kb, input int ab, input int nv);
      @(posedge clk); #1;
      kern_base = ADDR_BW'(kb);
      act_base  = ADDR_BW'(ab);
      num_vec   = CNT_BW'(nv);
      start     = 1'b1;
      start_cyc = cyc + 1;
      @(posedge clk); #1;
      start = 1'b0;
      in_op = 1'b1;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n0;
      n0 = done_cnt;
      for (int i = 0; i < budget && done_cnt == n0; i++) @(negedge clk);
      check({tag, "_done_seen"}, done_cnt - n0, 1);
      repeat (6) @(posedge clk);
      #1;
      check({tag, "_single_done"}, done_cnt - n0, 1);
   endtask

   task automatic check_logs(input string tag);
      check({tag, "_n_rd"}, addr_log.size(), exp_addr.size());
      for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
         check($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_addr[i]);
      check({tag, "_n_inst"}, inst_log.size(), exp_inst.size());
      for (int i = 0; i < inst_log.size() && i < exp_inst.size(); i++)
         check($sformatf("%s_inst%0d", tag, i), inst_log[i], exp_inst[i]);
      check({tag, "_n_psum"}, psum_log.size(), exp_psum.size());
      for (int i = 0; i < psum_log.size() && i < exp_psum.size(); i++)
         check($sformatf("%s_psum%0d", tag, i), psum_log[i], exp_psum[i]);
      check({tag, "_busy_gap"}, busy_gap, 0);
   endtask

   task automatic set_test1_expect();
      exp_addr = {0, 16, 17, 18, 19};
      exp_inst = {1, 2, 2, 2, 2};
      exp_psum = {1, 3, 36, 120};
   endtask

   initial begin
      for (int i = 0; i < (1 << ADDR_BW); i++) sram[i] = '0;
      sram[0]    = 32'h1111_1111;
      sram[1]    = 32'h0000_0003;
      sram[5]    = 32'h1111_1111;
      sram[16]   = 32'h0000_0001;
      sram[17]   = 32'h0000_0021;
      sram[18]   = 32'h8765_4321;
      sram[19]   = 32'hFFFF_FFFF;
      sram[1022] = 32'h0000_0005;
      sram[1023] = 32'h0000_0007;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", {mem_rd, mem_addr, inst_w, psum_out, psum_vld, busy, done, err}, 64'd0);
      check("reset_in_n", in_n, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);

      // 1: basic operation
      clear_logs();
      pulse_start(0, 16, 4);
      wait_done("t1", 200);
      set_test1_expect();
      check_logs("t1");
      check("t1_first_rd", first_rd, start_cyc + 1);
      check("t1_rd_span", last_rd - first_rd, 4);
      check("t1_inst_lag", first_inst, first_rd + 1);
      check("t1_err", err, 0);
      check("t1_idle_busy", busy, 0);

      // 2: zero vectors
      clear_logs();
      pulse_start(0, 16, 0);
      wait_done("t2", 50);
      exp_addr = {0};
      exp_inst = {1};
      exp_psum.delete();
      check_logs("t2");
      check("t2_done_lat", done_cyc - start_cyc, 2);

      // 3: activation address wrap
      clear_logs();
      pulse_start(5, 1022, 4);
      wait_done("t3", 200);
      exp_addr = {5, 1022, 1023, 0, 1};
      exp_inst = {1, 2, 2, 2, 2};
      exp_psum = {5, 7, 8, 3};
      check_logs("t3");

      // 4: start during EXEC is ignored
      clear_logs();
      pulse_start(0, 16, 4);
      @(posedge clk); #1;
      check("t4_in_exec_rd", mem_rd, 1);
      kern_base = ADDR_BW'(100);
      act_base  = ADDR_BW'(200);
      num_vec   = CNT_BW'(7);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t4", 200);
      set_test1_expect();
      check_logs("t4");

      // 5: drain timeout then err cleared by next start
      clear_logs();
      valid_off = 1'b1;
      pulse_start(0, 16, 2);
      wait_done("t5", 300);
      valid_off = 1'b0;
      check("t5_err_set", err, 1);
      check("t5_timeout_len", done_cyc - last_rd, DRAIN_MAX + 1);
      check("t5_no_psum", psum_log.size(), 0);
      repeat (4) @(posedge clk); #1;
      check("t5_err_sticky", err, 1);
      clear_logs();
      pulse_start(0, 16, 0);
      check("t5_err_cleared", err, 0);
      wait_done("t5b", 50);

      // 6: reset mid-EXEC, then a clean restart
      clear_logs();
      pulse_start(0, 16, 4);
      @(posedge clk); #3;
      reset = 1'b0;
      #1;
      check("t6_reset_outputs", {mem_rd, mem_addr, inst_w, psum_out, psum_vld, busy, done, err}, 64'd0);
      begin
         int n0;
         n0 = done_cnt;
         in_op = 1'b0;
         repeat (3) @(posedge clk); #1;
         reset = 1'b1;
         repeat (4) @(posedge clk); #1;
         check("t6_no_done", done_cnt - n0, 0);
         check("t6_idle_busy", busy, 0);
      end
      clear_logs();
      pulse_start(0, 16, 4);
      wait_done("t6", 200);
      set_test1_expect();
      check_logs("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
